ramen_order_dispatcher: RTL and testbench

- Customer-side driver for the ramen shop order interface; it generates the `selling`/`in_valid`/`ramen_type`/`portion` sequence and consumes the shop's order and total responses.
- Buffers upstream orders in a small FIFO and frames each session with `selling`.
- Issues each order as a two-beat transfer and waits for its verdict.
- At session end, captures the shop's totals, cross-checks them against its own tally, and emits a one-cycle report.

---
 rtl/ramen_order_dispatcher_if.sv | 22 ++
 rtl/ramen_order_dispatcher.sv | 236 +++++++++++++++++++++++
 tb/tb_ramen_order_dispatcher.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ramen_order_dispatcher_if.sv
// Shop-side order bus between the customer dispatcher (master) and the ramen shop (slave).
interface ramen_order_dispatcher_if;
  logic        selling;
  logic        in_valid;
  logic [1:0]  ramen_type;
  logic        portion;
  logic        out_valid_order;
  logic        success;
  logic        out_valid_tot;
  logic [27:0] sold_num;
  logic [14:0] total_gain;

  modport master (
    output selling, in_valid, ramen_type, portion,
    input  out_valid_order, success, out_valid_tot, sold_num, total_gain
  );

  modport slave (
    input  selling, in_valid, ramen_type, portion,
    output out_valid_order, success, out_valid_tot, sold_num, total_gain
  );
endinterface

// File: rtl/ramen_order_dispatcher.sv
// Customer-side ramen order dispatcher: buffers upstream orders, frames sessions with
// selling, issues two-beat orders, tallies verdicts and cross-checks the shop totals.
module ramen_order_dispatcher #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ord_valid,
  output logic       ord_ready,
  input  logic [1:0] ord_type,
  input  logic       ord_portion,
  input  logic       ord_last,
  ramen_order_dispatcher_if.master shop,
  output logic       rpt_valid,
  output logic [7:0] rpt_ok_cnt,
  output logic [7:0] rpt_fail_cnt,
  output logic       rpt_mismatch,
  output logic       rpt_timeout
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, OPEN, BEAT1, BEAT2, WAIT_RESP, GAP, CLOSE, WAIT_TOT, REPORT
  } state_e;

  state_e state_q, state_d;

  // Order FIFO: entry = {type, portion, last}
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push, pop, fifo_empty;
  logic [3:0]    head;

  assign ord_ready  = (cnt_q != (AW+1)'(FIFO_DEPTH));
  assign push       = ord_valid && ord_ready;
  assign pop        = (state_q == BEAT2);
  assign fifo_empty = (cnt_q == '0);
  assign head       = mem_q[rd_q];

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {ord_type, ord_portion, ord_last};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Session tallies and wait timer
  logic [6:0]    type_cnt_q [4];
  logic [7:0]    ok_q, fail_q;
  logic          to_q, last_q;
  logic [1:0]    type_q;
  logic [TW-1:0] tmr_q;
  logic          tmo, resp, resp_tmo, tot, tot_tmo;

  assign tmo      = (tmr_q == TW'(TIMEOUT - 1));
  assign resp     = (state_q == WAIT_RESP) && shop.out_valid_order;
  assign resp_tmo = (state_q == WAIT_RESP) && !shop.out_valid_order && tmo;
  assign tot      = (state_q == WAIT_TOT) && shop.out_valid_tot;
  assign tot_tmo  = (state_q == WAIT_TOT) && !shop.out_valid_tot && tmo;

  // Expected shop totals from the internal per-type counters
  logic [27:0] exp_sold;
  logic [14:0] exp_gain;
  logic        mm_now;

  assign exp_sold = {type_cnt_q[0], type_cnt_q[1], type_cnt_q[2], type_cnt_q[3]};
  assign exp_gain = 15'(16'd200 * (16'(type_cnt_q[0]) + 16'(type_cnt_q[2]))
                      + 16'd250 * (16'(type_cnt_q[1]) + 16'(type_cnt_q[3])));
  // A missing totals strobe is reported as a mismatch as well
  assign mm_now   = tot ? ((shop.sold_num != exp_sold) || (shop.total_gain != exp_gain)) : 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty) state_d = OPEN;
      OPEN:      state_d = BEAT1;
      BEAT1:     state_d = BEAT2;
      BEAT2:     state_d = WAIT_RESP;
      WAIT_RESP: if (resp || resp_tmo) begin
                   if (last_q)           state_d = CLOSE;
                   else if (!fifo_empty) state_d = BEAT1;
                   else                  state_d = GAP;
                 end
      GAP:       if (!fifo_empty) state_d = BEAT1;
      CLOSE:     state_d = WAIT_TOT;
      WAIT_TOT:  if (tot || tot_tmo) state_d = REPORT;
      REPORT:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Tally updates, head latching and the response/totals timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) type_cnt_q[i] <= '0;
      ok_q   <= '0;
      fail_q <= '0;
      to_q   <= 1'b0;
      last_q <= 1'b0;
      type_q <= '0;
      tmr_q  <= '0;
    end else begin
      if (state_q == IDLE) begin
        for (int unsigned i = 0; i < 4; i++) type_cnt_q[i] <= '0;
        ok_q   <= '0;
        fail_q <= '0;
        to_q   <= 1'b0;
      end
      if (state_q == BEAT2) begin
        type_q <= head[3:2];
        last_q <= head[0];
      end
      if (resp) begin
        if (shop.success) begin
          if (ok_q != '1) ok_q <= ok_q + 8'd1;
          if (type_cnt_q[type_q] != '1) type_cnt_q[type_q] <= type_cnt_q[type_q] + 7'd1;
        end else if (fail_q != '1) begin
          fail_q <= fail_q + 8'd1;
        end
      end
      if (resp_tmo) begin
        if (fail_q != '1) fail_q <= fail_q + 8'd1;
        to_q <= 1'b1;
      end
      if (tot_tmo) to_q <= 1'b1;
      if ((state_q == WAIT_RESP || state_q == WAIT_TOT) && state_d == state_q)
        tmr_q <= tmr_q + TW'(1);
      else
        tmr_q <= '0;
    end
  end

  // Output decode from the upcoming state so every output is a flop
  logic       selling_d, in_valid_d, portion_d, rpt_valid_d, rpt_mm_d, rpt_to_d;
  logic [1:0] type_d;
  logic [7:0] rpt_ok_d, rpt_fail_d;

  always_comb begin
    selling_d   = 1'b0;
    in_valid_d  = 1'b0;
    type_d      = '0;
    portion_d   = 1'b0;
    rpt_valid_d = 1'b0;
    rpt_ok_d    = '0;
    rpt_fail_d  = '0;
    rpt_mm_d    = 1'b0;
    rpt_to_d    = 1'b0;
    case (state_d)
      OPEN, WAIT_RESP, GAP: selling_d = 1'b1;
      BEAT1: begin
        selling_d  = 1'b1;
        in_valid_d = 1'b1;
        type_d     = head[3:2];
      end
      BEAT2: begin
        selling_d  = 1'b1;
        in_valid_d = 1'b1;
        portion_d  = head[1];
      end
      REPORT: begin
        rpt_valid_d = 1'b1;
        rpt_ok_d    = ok_q;
        rpt_fail_d  = fail_q;
        rpt_mm_d    = mm_now;
        rpt_to_d    = to_q || tot_tmo;
      end
      default: ;
    endcase
  end

  logic       selling_q, in_valid_q, portion_q, rpt_valid_q, rpt_mm_q, rpt_to_q;
  logic [1:0] type_out_q;
  logic [7:0] rpt_ok_q, rpt_fail_q;

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selling_q   <= 1'b0;
      in_valid_q  <= 1'b0;
      type_out_q  <= '0;
      portion_q   <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_ok_q    <= '0;
      rpt_fail_q  <= '0;
      rpt_mm_q    <= 1'b0;
      rpt_to_q    <= 1'b0;
    end else begin
      selling_q   <= selling_d;
      in_valid_q  <= in_valid_d;
      type_out_q  <= type_d;
      portion_q   <= portion_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_ok_q    <= rpt_ok_d;
      rpt_fail_q  <= rpt_fail_d;
      rpt_mm_q    <= rpt_mm_d;
      rpt_to_q    <= rpt_to_d;
    end
  end

  assign shop.selling    = selling_q;
  assign shop.in_valid   = in_valid_q;
  assign shop.ramen_type = type_out_q;
  assign shop.portion    = portion_q;
  assign rpt_valid       = rpt_valid_q;
  assign rpt_ok_cnt      = rpt_ok_q;
  assign rpt_fail_cnt    = rpt_fail_q;
  assign rpt_mismatch    = rpt_mm_q;
  assign rpt_timeout     = rpt_to_q;

endmodule

// File: tb/tb_ramen_order_dispatcher.sv
// Directed self-checking bench for ramen_order_dispatcher.
module tb_ramen_order_dispatcher;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ord_valid, ord_ready, ord_portion, ord_last;
  logic [1:0] ord_type;
  logic       rpt_valid, rpt_mismatch, rpt_timeout;
  logic [7:0] rpt_ok_cnt, rpt_fail_cnt;
  int total = 0;
  int bad   = 0;

  ramen_order_dispatcher_if shop_if ();

  ramen_order_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_type(ord_type),
    .ord_portion(ord_portion), .ord_last(ord_last),
    .shop(shop_if),
    .rpt_valid(rpt_valid), .rpt_ok_cnt(rpt_ok_cnt), .rpt_fail_cnt(rpt_fail_cnt),
    .rpt_mismatch(rpt_mismatch), .rpt_timeout(rpt_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic p, input logic l);
    ord_valid = 1'b1; ord_type = t; ord_portion = p; ord_last = l;
    for (int i = 0; i < 60; i++) begin
      if (ord_ready) break;
      @(negedge clk);
    end
    check("push_ready", 32'(ord_ready), 32'd1);
    @(negedge clk);
    ord_valid = 1'b0;
  endtask

  task automatic expect_beats(input logic [1:0] t, input logic p);
    for (int i = 0; i < 40; i++) begin
      if (shop_if.in_valid) break;
      @(negedge clk);
    end
    check("beat1_valid", 32'(shop_if.in_valid), 32'd1);
    check("beat1_type", 32'(shop_if.ramen_type), 32'(t));
    check("beat1_portion", 32'(shop_if.portion), 32'd0);
    @(negedge clk);
    check("beat2_valid", 32'(shop_if.in_valid), 32'd1);
    check("beat2_type", 32'(shop_if.ramen_type), 32'd0);
    check("beat2_portion", 32'(shop_if.portion), 32'(p));
    @(negedge clk);
    check("beat_end", 32'(shop_if.in_valid), 32'd0);
  endtask

  task automatic respond(input logic s);
    shop_if.out_valid_order = 1'b1; shop_if.success = s;
    @(negedge clk);
    shop_if.out_valid_order = 1'b0; shop_if.success = 1'b0;
  endtask

  task automatic totals(input logic [27:0] sold, input logic [14:0] gain);
    @(negedge clk);
    shop_if.out_valid_tot = 1'b1; shop_if.sold_num = sold; shop_if.total_gain = gain;
    @(negedge clk);
    shop_if.out_valid_tot = 1'b0; shop_if.sold_num = '0; shop_if.total_gain = '0;
  endtask

  task automatic expect_report(input logic [7:0] ok, input logic [7:0] fl, input logic mm, input logic to);
    for (int i = 0; i < 60; i++) begin
      if (rpt_valid) break;
      @(negedge clk);
    end
    check("rpt_valid", 32'(rpt_valid), 32'd1);
    check("rpt_ok", 32'(rpt_ok_cnt), 32'(ok));
    check("rpt_fail", 32'(rpt_fail_cnt), 32'(fl));
    check("rpt_mismatch", 32'(rpt_mismatch), 32'(mm));
    check("rpt_timeout", 32'(rpt_timeout), 32'(to));
    @(negedge clk);
    check("rpt_one_cycle", 32'(rpt_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    rst_n = 1'b0;
    ord_valid = 1'b0; ord_type = '0; ord_portion = 1'b0; ord_last = 1'b0;
    shop_if.out_valid_order = 1'b0; shop_if.success = 1'b0;
    shop_if.out_valid_tot = 1'b0; shop_if.sold_num = '0; shop_if.total_gain = '0;

    // reset state
    @(negedge clk);
    check("rst_selling", 32'(shop_if.selling), 32'd0);
    check("rst_in_valid", 32'(shop_if.in_valid), 32'd0);
    check("rst_type", 32'(shop_if.ramen_type), 32'd0);
    check("rst_portion", 32'(shop_if.portion), 32'd0);
    check("rst_rpt", {rpt_valid, rpt_mismatch, rpt_timeout, rpt_ok_cnt, rpt_fail_cnt}, 32'd0);
    check("rst_ready", 32'(ord_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // stray strobes in IDLE must be ignored
    shop_if.out_valid_order = 1'b1; shop_if.success = 1'b1; shop_if.out_valid_tot = 1'b1;
    @(negedge clk);
    shop_if.out_valid_order = 1'b0; shop_if.success = 1'b0; shop_if.out_valid_tot = 1'b0;
    check("stray_idle", 32'(shop_if.selling), 32'd0);

    // 1: single tonkotsu big, success
    push(2'd0, 1'b1, 1'b1);
    expect_beats(2'd0, 1'b1);
    check("t1_selling_wait", 32'(shop_if.selling), 32'd1);
    respond(1'b1);
    check("t1_selling_fall", 32'(shop_if.selling), 32'd0);
    totals(28'h0200000, 15'd200);
    expect_report(8'd1, 8'd0, 1'b0, 1'b0);

    // 2: two miso_soy small, correct totals then a wrong gain
    push(2'd3, 1'b0, 1'b0);
    push(2'd3, 1'b0, 1'b1);
    expect_beats(2'd3, 1'b0);
    respond(1'b1);
    expect_beats(2'd3, 1'b0);
    respond(1'b1);
    totals(28'h0000002, 15'd500);
    expect_report(8'd2, 8'd0, 1'b0, 1'b0);
    push(2'd3, 1'b0, 1'b0);
    push(2'd3, 1'b0, 1'b1);
    expect_beats(2'd3, 1'b0);
    respond(1'b1);
    expect_beats(2'd3, 1'b0);
    respond(1'b1);
    totals(28'h0000002, 15'd450);
    expect_report(8'd2, 8'd0, 1'b1, 1'b0);

    // 3: rejected order
    push(2'd1, 1'b1, 1'b1);
    expect_beats(2'd1, 1'b1);
    respond(1'b0);
    totals(28'h0000000, 15'd0);
    expect_report(8'd0, 8'd1, 1'b0, 1'b0);

    // 4: verdict timeout, session continues, then totals timeout
    push(2'd2, 1'b0, 1'b0);
    push(2'd2, 1'b1, 1'b1);
    expect_beats(2'd2, 1'b0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (shop_if.in_valid) break;
    end
    check("t4_resp_tmo_cycles", 32'(cyc), 32'd15);
    check("t4_selling_held", 32'(shop_if.selling), 32'd1);
    expect_beats(2'd2, 1'b1);
    respond(1'b1);
    expect_report(8'd1, 8'd1, 1'b1, 1'b1);

    // 5: FIFO fills while an order is outstanding
    push(2'd1, 1'b1, 1'b0);
    expect_beats(2'd1, 1'b1);
    push(2'd0, 1'b0, 1'b0);
    push(2'd1, 1'b1, 1'b0);
    push(2'd2, 1'b0, 1'b0);
    push(2'd3, 1'b1, 1'b0);
    check("t5_full_ready", 32'(ord_ready), 32'd0);
    fork
      push(2'd2, 1'b1, 1'b1);
      begin
        respond(1'b1);
        expect_beats(2'd0, 1'b0);
      end
    join
    respond(1'b1);
    expect_beats(2'd1, 1'b1);
    respond(1'b1);
    expect_beats(2'd2, 1'b0);
    respond(1'b1);
    expect_beats(2'd3, 1'b1);
    respond(1'b1);
    expect_beats(2'd2, 1'b1);
    respond(1'b1);
    totals(28'h0208101, 15'd1350);
    expect_report(8'd6, 8'd0, 1'b0, 1'b0);

    // 6: reset during WAIT_RESP
    push(2'd1, 1'b0, 1'b1);
    expect_beats(2'd1, 1'b0);
    check("t6_selling_before", 32'(shop_if.selling), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_selling", 32'(shop_if.selling), 32'd0);
    check("t6_rst_in_valid", 32'(shop_if.in_valid), 32'd0);
    check("t6_rst_ready", 32'(ord_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rpt_valid || shop_if.selling) seen = 1'b1;
    end
    check("t6_quiet_after_rst", 32'(seen), 32'd0);
    push(2'd2, 1'b1, 1'b1);
    expect_beats(2'd2, 1'b1);
    respond(1'b1);
    totals(28'h0000080, 15'd200);
    expect_report(8'd1, 8'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
